// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
//
// Contents: operation enum (matches funct3), FSM state enum, step-mode enum,
// iteration count, divide-by-zero quotient, and a conditional absolute-value helper.
package muldiv_pkg;

  localparam int          MULDIV_ITER = 32;
  localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

  // Two's-complement magnitude when the operand is treated as signed and is negative.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] abs_val(input logic [31:0] v, input logic is_signed);
    abs_val = (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide over a shared 33-bit add/sub.
// Latency: combinational.
// Backpressure: none; the sequencer decides when the result is registered.
//
// Ports: mode     - STEP_MUL or STEP_DIV
//        acc      - 64-bit accumulator ({hi,lo} for multiply, {rem,quo} for divide)
//        operand  - multiplicand (multiply) or divisor (divide) magnitude
//        acc_next - accumulator after one iteration
module muldiv_step
  import muldiv_pkg::*;
(
  input  step_mode_e  mode,
  input  logic [63:0] acc,
  input  logic [31:0] operand,
  output logic [63:0] acc_next
);

  logic [32:0] add_a;
  logic [32:0] add_b;
  logic        sub;
  logic [33:0] sum;
  logic        no_borrow;
  logic [31:0] rem_new;

  always_comb begin
    add_a     = '0;
    add_b     = '0;
    sub       = 1'b0;
    sum       = '0;
    no_borrow = 1'b0;
    rem_new   = '0;
    acc_next  = acc;

    if (mode == STEP_DIV) begin
      // Shifted partial remainder can reach 33 bits before the trial subtract.
      add_a = {acc[63:32], acc[31]};
      add_b = {1'b0, operand};
      sub   = 1'b1;
    end else begin
      // Conditional add: a zero addend when the multiplier bit is clear.
      add_a = {1'b0, acc[63:32]};
      add_b = acc[0] ? {1'b0, operand} : 33'd0;
      sub   = 1'b0;
    end

    sum = {1'b0, add_a} + {1'b0, (sub ? ~add_b : add_b)} + {33'd0, sub};

    if (mode == STEP_DIV) begin
      // Carry out of a + ~b + 1 means a >= b; the difference then fits in 32 bits.
      no_borrow = sum[33];
      rem_new   = no_borrow ? sum[31:0] : add_a[31:0];
      acc_next  = {rem_new, acc[30:0], no_borrow};
    end else begin
      // Shift {carry,hi,lo} right by one.
      acc_next = {sum[32:0], acc[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer with start/ready handshake and kill.
// Latency: 34 cycles accept-to-valid (1 cycle for trivial requests when MULDIV_EARLY_OUT_EN).
// Backpressure: ready_o low while busy; start_i outside IDLE is dropped, nothing queued.
//
// Ports: clk_i, rst_i (sync, active-high), start_i/op_i/operand1_i/operand2_i request,
//        kill_i abort, ready_o (IDLE), busy_o (CALC/FIX/DONE), valid_o (one-cycle strobe),
//        result_o (registered, held until the next accepted request completes).
// Build option: define MULDIV_EARLY_OUT_EN to send divide-by-zero, signed overflow and
//        multiply-by-zero straight from IDLE to DONE.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] operand1_i,
  input  logic [XLEN-1:0] operand2_i,
  input  logic            kill_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  muldiv_state_e state_q, state_d;

  muldiv_op_e        op_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   oper_q;
  logic [XLEN-1:0]   op1_q;
  logic              neg_q;
  logic              div0_q;
  logic [4:0]        cnt_q;
  logic [XLEN-1:0]   result_q;

  // ---------------- request decode (IDLE) ----------------
  muldiv_op_e      op_in;
  logic            sgn1, sgn2, neg1, neg2, in_div, in_div0, in_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic            accept;

  assign op_in  = muldiv_op_e'(op_i);
  assign accept = (state_q == ST_IDLE) && start_i && !kill_i;

  always_comb begin
    sgn1    = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    sgn2    = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    neg1    = sgn1 && operand1_i[XLEN-1];
    neg2    = sgn2 && operand2_i[XLEN-1];
    mag1    = abs_val(operand1_i, sgn1);
    mag2    = abs_val(operand2_i, sgn2);
    in_div  = op_i[2];
    in_div0 = in_div && (operand2_i == '0);
    // Remainder takes the dividend's sign; everything else takes the product of signs.
    in_neg  = (op_in == OP_REM) ? neg1 : (neg1 ^ neg2);
  end

  // ---------------- early-out classification ----------------
  logic            trivial;
  logic [XLEN-1:0] triv_result;

`ifdef MULDIV_EARLY_OUT_EN
  logic ovf;
  always_comb begin
    trivial     = 1'b0;
    triv_result = '0;
    ovf         = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                  (operand1_i == 32'h8000_0000) && (operand2_i == 32'hFFFF_FFFF);
    if (in_div0) begin
      trivial     = 1'b1;
      triv_result = op_i[1] ? operand1_i : DIV0_QUOT;
    end else if (ovf) begin
      trivial     = 1'b1;
      triv_result = op_i[1] ? 32'd0 : 32'h8000_0000;
    end else if (!in_div && ((operand1_i == '0) || (operand2_i == '0))) begin
      trivial     = 1'b1;
      triv_result = '0;
    end
  end
`else
  assign trivial     = 1'b0;
  assign triv_result = '0;
`endif

  // ---------------- iteration datapath ----------------
  step_mode_e        step_mode;
  logic [2*XLEN-1:0] step_acc;

  assign step_mode = op_q[2] ? STEP_DIV : STEP_MUL;

  muldiv_step u_step (
    .mode     (step_mode),
    .acc      (acc_q),
    .operand  (oper_q),
    .acc_next (step_acc)
  );

  // ---------------- sign / corner-case fix ----------------
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem, fix_result;

  always_comb begin
    prod_s = neg_q ? ((2*XLEN)'(0) - acc_q) : acc_q;
    quo    = acc_q[XLEN-1:0];
    rem    = acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        fix_result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_result = div0_q ? DIV0_QUOT : (neg_q ? (32'd0 - quo) : quo);
      default:                       fix_result = div0_q ? op1_q : (neg_q ? (32'd0 - rem) : rem);
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = trivial ? ST_DONE : ST_CALC;
      ST_CALC: begin
        if (kill_i)              state_d = ST_IDLE;
        else if (cnt_q == 5'd0)  state_d = ST_FIX;
      end
      ST_FIX:  state_d = kill_i ? ST_IDLE : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- data registers ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= OP_MUL;
      acc_q    <= '0;
      oper_q   <= '0;
      op1_q    <= '0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= op_in;
            op1_q  <= operand1_i;
            neg_q  <= in_neg;
            div0_q <= in_div0;
            cnt_q  <= 5'(MULDIV_ITER - 1);
            if (in_div) begin
              acc_q  <= {{XLEN{1'b0}}, mag1};
              oper_q <= mag2;
            end else begin
              acc_q  <= {{XLEN{1'b0}}, mag2};
              oper_q <= mag1;
            end
            if (trivial) result_q <= triv_result;
          end
        end
        ST_CALC: begin
          acc_q <= step_acc;
          cnt_q <= cnt_q - 5'd1;
        end
        ST_FIX: begin
          if (!kill_i) result_q <= fix_result;
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_q == ST_IDLE);
  assign busy_o   = (state_q != ST_IDLE);
  assign valid_o  = (state_q == ST_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: table of operations with hand-computed
// results and latencies, then kill / reset / start-while-busy sequences.
module tb_muldiv_seq;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] operand1_i = '0;
  logic [31:0] operand2_i = '0;
  logic        kill_i = 1'b0;
  logic        ready_o, busy_o, valid_o;
  logic [31:0] result_o;

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .op_i       (op_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .kill_i     (kill_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          triv;
  } vec_t;

  vec_t vecs[18];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request at a negedge once ready; it is accepted at the following posedge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    for (int w = 0; w < 100 && !ready_o; w++) @(negedge clk);
    start_i    = 1'b1;
    op_i       = op;
    operand1_i = a;
    operand2_i = b;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // Latency k means valid_o seen in the cycle after accept edge + k; -1 on timeout.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    lat = -1;
    res = '0;
    start_op(op, a, b);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (valid_o) begin
        lat = k;
        res = result_o;
        break;
      end
    end
  endtask

  task automatic count_valids(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (valid_o) n++;
    end
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          nv;
    int          n_acc;
    int          n_val;

    vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0}; // MUL 7*-3
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0}; // MULH
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0}; // MULHU
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0}; // MULHSU -1*(2^32-1)
    vecs[4]  = '{3'b000, 32'd0,         32'd5,         32'd0,         1'b1}; // MUL by zero
    vecs[5]  = '{3'b001, 32'h1234_5678, 32'd0,         32'd0,         1'b1}; // MULH by zero
    vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        1'b0}; // DIVU
    vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         1'b0}; // REMU
    vecs[8]  = '{3'b100, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0}; // DIV -100/7
    vecs[9]  = '{3'b110, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 1'b0}; // REM -100/7
    vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1}; // DIV overflow
    vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1}; // REM overflow
    vecs[12] = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1}; // DIV by zero
    vecs[13] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1}; // REM -5/0
    vecs[14] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0}; // DIV 7/-2
    vecs[15] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0}; // REM 7/-2
    vecs[16] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0}; // DIVU big divisor
    vecs[17] = '{3'b111, 32'd7,         32'd0,         32'd7,         1'b1}; // REMU by zero

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    check("reset ready", 32'(ready_o), 32'd1);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset valid", 32'(valid_o), 32'd0);
    check("reset result", result_o, 32'd0);
    rst_i = 1'b0;

    // Table-driven operations: result, latency, one-cycle strobe, held result.
    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d result", i), res, vecs[i].res);
      check($sformatf("vec%0d latency", i), 32'(lat), (EARLY && vecs[i].triv) ? 32'd1 : 32'd34);
      @(negedge clk);
      check($sformatf("vec%0d valid one cycle", i), 32'(valid_o), 32'd0);
      check($sformatf("vec%0d result held", i), result_o, vecs[i].res);
    end

    // Establish a known prior result.
    run_op(3'b000, 32'd6, 32'd7, res, lat);
    check("mul 6*7", res, 32'd42);

    // Kill in CALC, sampled at accept edge + 10.
    start_op(3'b101, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0;
    @(negedge clk);
    check("kill calc ready", 32'(ready_o), 32'd1);
    check("kill calc busy", 32'(busy_o), 32'd0);
    count_valids(40, nv);
    check("kill calc no valid", 32'(nv), 32'd0);
    check("kill calc result kept", result_o, 32'd42);

    // New request right after the kill completes normally.
    run_op(3'b101, 32'd1000, 32'd10, res, lat);
    check("post-kill result", res, 32'd100);
    check("post-kill latency", 32'(lat), 32'd34);

    // Kill during FIX (FIX occupies the cycle after accept edge + 33).
    start_op(3'b111, 32'd100, 32'd7);
    repeat (33) @(negedge clk);
    check("fix busy", 32'(busy_o), 32'd1);
    kill_i = 1'b1;
    @(posedge clk);
    #1 kill_i = 1'b0;
    @(negedge clk);
    check("kill fix ready", 32'(ready_o), 32'd1);
    count_valids(40, nv);
    check("kill fix no valid", 32'(nv), 32'd0);
    check("kill fix result kept", result_o, 32'd100);

    // Start together with kill in IDLE is dropped.
    @(negedge clk);
    start_i = 1'b1; kill_i = 1'b1;
    op_i = 3'b000; operand1_i = 32'd3; operand2_i = 32'd3;
    @(posedge clk);
    #1 begin start_i = 1'b0; kill_i = 1'b0; end
    @(negedge clk);
    check("start+kill dropped", 32'(ready_o), 32'd1);
    count_valids(40, nv);
    check("start+kill no valid", 32'(nv), 32'd0);

    // Reset mid-CALC, sampled at accept edge + 20.
    start_op(3'b000, 32'd6, 32'd7);
    repeat (19) @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("midrst ready", 32'(ready_o), 32'd1);
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst valid", 32'(valid_o), 32'd0);
    check("midrst result", result_o, 32'd0);
    count_valids(40, nv);
    check("midrst no valid", 32'(nv), 32'd0);

    // start_i held high for 100 cycles: accepts at 0, 35, 70.
    n_acc = 0;
    n_val = 0;
    @(negedge clk);
    start_i = 1'b1; op_i = 3'b000; operand1_i = 32'd6; operand2_i = 32'd7;
    for (int k = 0; k < 100; k++) begin
      if (ready_o) n_acc++;
      if (valid_o) n_val++;
      @(negedge clk);
    end
    start_i = 1'b0;
    count_valids(40, nv);
    n_val += nv;
    check("burst accepts", 32'(n_acc), 32'd3);
    check("burst valids", 32'(n_val), 32'd3);
    check("burst result", result_o, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

- Iterative RV32M multiply/divide sequencer beside the single-cycle ALU in the execute stage.
- Accepts one operation via a start/ready handshake and runs 32 shift-add or restoring-divide iterations over a 33-bit add/sub step.
- Applies sign correction and the RISC-V corner-case rules, then presents a one-cycle valid result.
- The core control unit stalls the PC while `busy_o` is high.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; only 32 is supported.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  request; accepted only when `ready_o`=1.
- `op_i`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand1_i`  in  32  rs1 (multiplicand/dividend).
- `operand2_i`  in  32  rs2 (multiplier/divisor).
- `kill_i`  in  1  abort the operation in flight (pipeline flush).
- `ready_o`  out  1  high only in IDLE.
- `busy_o`  out  1  high in CALC, FIX and DONE.
- `valid_o`  out  1  one-cycle result strobe (DONE state).
- `result_o`  out  32  result; holds its value until the next accepted request.

## Operation
- **FSM states:** IDLE, CALC, FIX, DONE.
- **IDLE:**
  - `start_i`=1 latches `op_i` and the operand magnitudes.
  - Magnitude: two's-complement absolute value for signed operands (MULH: both; MULHSU: rs1 only; DIV/REM: both); MUL, MULHU, DIVU and REMU use raw operands.
  - Records result sign and the divide-by-zero flag.
  - Loads iteration counter = 31; goes to CALC.
- **CALC, multiply:**
  - 64-bit `{hi,lo}` accumulator; lo preloaded with the multiplier.
  - Each cycle: if lo[0], hi += multiplicand (33-bit with carry); then shift `{carry,hi,lo}` right by 1.
- **CALC, divide:**
  - Restoring division on the 64-bit `{rem,quo}` register; quo preloaded with the dividend.
  - Each cycle: shift left 1; trial = rem − divisor (33-bit).
  - If trial ≥ 0: rem = trial, quo[0] = 1.
- **CALC exit:** counter decrements each cycle; CALC → FIX when the counter is 0.
- **FIX:** selects the result and applies the RISC-V rules.
  - MUL → lo. MULH/MULHSU/MULHU → hi. A negative sign negates the 64-bit product before selection.
  - DIV/DIVU → quo, negated if the operand signs differ. REM/REMU → rem, negated if the dividend is negative.
  - Divide by zero is forced, overriding sign fix: quotient = 0xFFFFFFFF; remainder = original `operand1_i`.
  - Overflow (DIV 0x80000000 / −1) yields 0x80000000 and REM 0 naturally; no special path is needed.
- **DONE:** `valid_o`=1 for exactly one cycle, then IDLE.
- **Ignored inputs:** `start_i` outside IDLE is ignored; nothing is queued.
- **Kill:**
  - `kill_i`=1 in CALC or FIX: next state IDLE; `valid_o` is never raised; `result_o` is unchanged.
  - `kill_i` in DONE has no effect.
  - `kill_i` with `start_i` in IDLE: the start is dropped.
- **Reset:** `rst_i` in any state, including mid-CALC, gives IDLE, `ready_o`=1, `busy_o`=0, `valid_o`=0, `result_o`=0, counter=0. Reset has priority over kill and start.

## Timing
- Accept on edge N: CALC for cycles N+1..N+32, FIX at N+33, DONE (`valid_o`=1) at N+34, IDLE at N+35.
- Latency is 34 cycles, accept edge to the valid cycle. Throughput is one operation per 35 cycles.
- `result_o` is registered; it is stable from the DONE cycle until the next accept edge + 34.
- `ready_o` and `busy_o` are decoded from registered state; there is no combinational path from inputs.

## Configuration
- **`MULDIV_EARLY_OUT_EN`** defined: early-out path for trivial requests.
  - Trivial = divide by zero, DIV overflow, or any multiply with a zero operand.
  - These bypass CALC/FIX: IDLE → DONE directly, so `valid_o` at N+1.
  - Results are identical to the full path.
- **Undefined:** every operation takes the full 34-cycle latency.

## Structure
- **`muldiv_pkg`:**
  - `muldiv_op_e`: 3-bit enum matching funct3.
  - `muldiv_state_e`: IDLE/CALC/FIX/DONE.
  - Constants `MULDIV_ITER`=32 and `DIV0_QUOT`=32'hFFFFFFFF.
- **`muldiv_step`:** one combinational sub-module.
  - Inputs: mode, accumulator, operand.
  - Output: next accumulator for one iteration.
  - Holds the single 33-bit add/sub, shared by multiply and divide.
- FSM, counter and sign/fix logic live in `muldiv_seq`.

## Test plan
- MUL 7 × 0xFFFFFFFD → `valid_o` exactly 34 cycles after accept, `result_o`=0xFFFFFFEB; MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIV −100/7 → 0xFFFFFFF2; REM −100/7 → 0xFFFFFFFE.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0; DIV 5/0 → 0xFFFFFFFF; REM −5/0 → 0xFFFFFFFB. With `MULDIV_EARLY_OUT_EN` defined, all four give `valid_o` at N+1.
- `kill_i` at accept+10 → IDLE next cycle, no `valid_o` ever, `result_o` keeps the prior value; a new start next cycle completes normally.
- `rst_i` at accept+20 → all outputs at reset values next cycle; `start_i` pulsed every cycle while busy → exactly one `valid_o` per accepted request.
